collision_monitor: RTL

//  Multi-channel collision tracker for the snake game core. Each channel is one snake.
//  Per channel it samples the cell code under the head when the move engine strobes

---
 rtl/snake_pkg.sv | 25 ++
 rtl/collision_channel.sv | 130 +++++++++++++
 rtl/collision_monitor.sv | 76 +++++++
 3 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared cell/state types and fatal-cell helper for the collision monitor
package snake_pkg;

    // Cell code reported by the grid lookup for the cell under a snake head.
    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_FOOD  = 2'd1,
        CELL_BODY  = 2'd2,
        CELL_WALL  = 2'd3
    } cell_t;

    // Per-channel collision state.
    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HIT   = 2'd1,
        GRACE = 2'd2,
        DEAD  = 2'd3
    } ch_state_t;

    // A wall always kills; a body segment kills only when body_fatal is set.
    function automatic logic is_fatal(input cell_t s, input logic body_fatal);
        return (s == CELL_WALL) || (body_fatal && (s == CELL_BODY));
    endfunction

endpackage

// File: rtl/collision_channel.sv
// rtl/collision_channel.sv - per-snake collision FSM with lives, grace window and cause latch
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_listen       1-cycle strobe: i_status is valid this cycle
//   i_status       cell code under this snake's head
//   i_ack_edge     rising edge of the player acknowledge (shared by all channels)
//   o_collided     channel is in HIT
//   o_hit_pulse    1-cycle pulse on entry to HIT
//   o_cause        cell code of the most recent hit
//   o_food_pulse   1-cycle pulse on a food pickup while ALIVE or GRACE
//   o_lives        remaining lives
//   o_dead         channel has reached the terminal DEAD state
module collision_channel
    import snake_pkg::*;
#(
    parameter int  LIVES      = 3,
    parameter int  GRACE_CYC  = 16,
    parameter int  BODY_FATAL = 1,
    localparam int LIVES_W    = $clog2(LIVES + 1),
    localparam int CNT_W      = (GRACE_CYC > 1) ? $clog2(GRACE_CYC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_listen,
    input  cell_t              i_status,
    input  logic               i_ack_edge,
    output logic               o_collided,
    output logic               o_hit_pulse,
    output cell_t              o_cause,
    output logic               o_food_pulse,
    output logic [LIVES_W-1:0] o_lives,
    output logic               o_dead
);

    localparam logic              BODY_KILLS = (BODY_FATAL != 0);
    localparam logic [CNT_W-1:0]  GRACE_LOAD = CNT_W'(GRACE_CYC - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    ch_state_t          r_state;
    logic [CNT_W-1:0]   r_grace_cnt;
    logic [LIVES_W-1:0] r_lives;
    cell_t              r_cause;
    logic               r_collided;
    logic               r_hit_pulse;
    logic               r_food_pulse;

    logic w_fatal;
    logic w_food;

    assign w_fatal = i_listen && is_fatal(i_status, BODY_KILLS);
    assign w_food  = i_listen && (i_status == CELL_FOOD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ALIVE;
            r_grace_cnt  <= '0;
            r_lives      <= LIVES_INIT;
            r_cause      <= CELL_EMPTY;
            r_collided   <= 1'b0;
            r_hit_pulse  <= 1'b0;
            r_food_pulse <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-asserted below.
            r_hit_pulse  <= 1'b0;
            r_food_pulse <= 1'b0;

            case (r_state)
                ALIVE: begin
                    if (w_fatal) begin
                        r_state     <= HIT;
                        r_collided  <= 1'b1;
                        r_hit_pulse <= 1'b1;
                        r_cause     <= i_status;
                        // Saturate rather than wrap.
                        if (r_lives != '0) begin
                            r_lives <= r_lives - LIVES_W'(1);
                        end
                    end else if (w_food) begin
                        r_food_pulse <= 1'b1;
                    end
                end

                HIT: begin
                    // Head samples are meaningless while waiting for the player.
                    if (i_ack_edge) begin
                        r_collided <= 1'b0;
                        if (r_lives != '0) begin
                            r_state     <= GRACE;
                            r_grace_cnt <= GRACE_LOAD;
                        end else begin
                            r_state <= DEAD;
                        end
                    end
                end

                GRACE: begin
                    // Fatal cells are ignored here, including on the expiry cycle;
                    // the snake is vulnerable only from the cycle after expiry.
                    if (w_food) begin
                        r_food_pulse <= 1'b1;
                    end
                    if (r_grace_cnt == '0) begin
                        r_state <= ALIVE;
                    end else begin
                        r_grace_cnt <= r_grace_cnt - CNT_W'(1);
                    end
                end

                DEAD: begin
                    // Terminal until reset: lives and cause hold.
                    r_state <= DEAD;
                end

                default: begin
                    r_state    <= ALIVE;
                    r_collided <= 1'b0;
                end
            endcase
        end
    end

    assign o_collided   = r_collided;
    assign o_hit_pulse  = r_hit_pulse;
    assign o_cause      = r_cause;
    assign o_food_pulse = r_food_pulse;
    assign o_lives      = r_lives;
    assign o_dead       = (r_state == DEAD);

endmodule

// File: rtl/collision_monitor.sv
// rtl/collision_monitor.sv - multi-snake collision tracker: ack edge detect, channels, game over
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_listen       per-channel sample strobe
//   i_status       per-channel cell code under the head
//   i_ack          player acknowledge level, already synchronous to clk
//   o_collided     per-channel: in HIT
//   o_hit_pulse    per-channel: 1-cycle pulse on entry to HIT
//   o_cause        per-channel: cell code of the last hit
//   o_food_pulse   per-channel: 1-cycle food pickup pulse
//   o_lives        per-channel: remaining lives
//   o_game_over    every channel is DEAD (registered)
module collision_monitor
    import snake_pkg::*;
#(
    parameter int  N_CH       = 2,
    parameter int  LIVES      = 3,
    parameter int  GRACE_CYC  = 16,
    parameter int  BODY_FATAL = 1,
    localparam int LIVES_W    = $clog2(LIVES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic  [N_CH-1:0]              i_listen,
    input  cell_t [N_CH-1:0]              i_status,
    input  logic                          i_ack,
    output logic  [N_CH-1:0]              o_collided,
    output logic  [N_CH-1:0]              o_hit_pulse,
    output cell_t [N_CH-1:0]              o_cause,
    output logic  [N_CH-1:0]              o_food_pulse,
    output logic  [N_CH-1:0][LIVES_W-1:0] o_lives,
    output logic                          o_game_over
);

    // Reset to 1 so an ack held high through reset release is not seen as an edge.
    logic            r_ack_q;
    logic            r_game_over;
    logic            w_ack_edge;
    logic [N_CH-1:0] w_dead;

    assign w_ack_edge = i_ack && !r_ack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_q     <= 1'b1;
            r_game_over <= 1'b0;
        end else begin
            r_ack_q     <= i_ack;
            r_game_over <= &w_dead;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        collision_channel #(
            .LIVES      (LIVES),
            .GRACE_CYC  (GRACE_CYC),
            .BODY_FATAL (BODY_FATAL)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_listen     (i_listen[g]),
            .i_status     (i_status[g]),
            .i_ack_edge   (w_ack_edge),
            .o_collided   (o_collided[g]),
            .o_hit_pulse  (o_hit_pulse[g]),
            .o_cause      (o_cause[g]),
            .o_food_pulse (o_food_pulse[g]),
            .o_lives      (o_lives[g]),
            .o_dead       (w_dead[g])
        );
    end

    assign o_game_over = r_game_over;

endmodule
